// File: rtl/segment_ascii_streamer_if.sv
// Byte-stream handshake carrying the ASCII output of segment_ascii_streamer.
//   tx_data  : current ASCII byte
//   tx_valid : tx_data holds a byte to be taken
//   tx_ready : the sink takes the byte on a rising edge where tx_valid is high
// master = byte source (the streamer), slave = byte sink.
interface segment_ascii_streamer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/segment_ascii_streamer.sv
// Decodes NUM_DIGITS 7-segment patterns into ASCII digits and sends them
// most-significant digit first, optionally followed by CR LF.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   ss_in       : segment patterns, top 7 bits = most significant digit
//   start       : frame request (one pending request is kept while busy)
//   tx          : byte stream handshake (master side)
//   busy        : a frame is in progress
//   frame_err   : the last or current frame contained an unrecognised pattern
//
// state    | meaning
// ---------+---------------------------------------------
// ST_IDLE  | no frame; waiting for start, pending or auto trigger
// ST_DIGIT | presenting the decoded digit selected by idx
// ST_CR    | presenting 0x0D
// ST_LF    | presenting 0x0A; its transfer ends the frame
module segment_ascii_streamer #(
  parameter int         NUM_DIGITS = 2,
  parameter int         ADD_CRLF   = 1,
  parameter int         AUTO_SEND  = 0,
  parameter logic [7:0] BAD_CHAR   = 8'h3F
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7*NUM_DIGITS-1:0] ss_in,
  input  logic                    start,
  segment_ascii_streamer_if.master tx,
  output logic                    busy,
  output logic                    frame_err
);

  localparam int IW = $clog2(NUM_DIGITS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DIGIT, ST_CR, ST_LF} state_t;

  state_t                  state, state_nxt;
  logic [IW-1:0]           idx;
  logic [7*NUM_DIGITS-1:0] snapshot, last_sent;
  logic                    pending, err_q;
  logic                    trigger, xfer;
  logic [6:0]              cur_seg;
  logic [7:0]              cur_char;
  logic                    cur_bad;
  logic [7:0]              data;

  // Returns {bad, ascii}; bad marks a pattern that is not a decimal digit.
  function automatic logic [8:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: decode = {1'b0, 8'h30};
      7'b0110000: decode = {1'b0, 8'h31};
      7'b1101101: decode = {1'b0, 8'h32};
      7'b1111001: decode = {1'b0, 8'h33};
      7'b0110011: decode = {1'b0, 8'h34};
      7'b1011011: decode = {1'b0, 8'h35};
      7'b1011111: decode = {1'b0, 8'h36};
      7'b1110000: decode = {1'b0, 8'h37};
      7'b1111111: decode = {1'b0, 8'h38};
      7'b1111011: decode = {1'b0, 8'h39};
      default:    decode = {1'b1, BAD_CHAR};
    endcase
  endfunction

  // idx 0 selects the top field of the snapshot.
  always_comb begin
    cur_seg = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(NUM_DIGITS - 1 - i)) cur_seg = snapshot[7*i +: 7];
    end
  end

  assign {cur_bad, cur_char} = decode(cur_seg);

  assign xfer    = tx.tx_valid && tx.tx_ready;
  assign trigger = start || pending || ((AUTO_SEND != 0) && (ss_in != last_sent));

  always_comb begin
    data = 8'h00;
    case (state)
      ST_DIGIT: data = cur_char;
      ST_CR:    data = 8'h0D;
      ST_LF:    data = 8'h0A;
      default:  data = 8'h00;
    endcase
  end

  // Outputs derive from registered state, so reset clears them immediately.
  assign tx.tx_data  = data;
  assign tx.tx_valid = (state != ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign frame_err   = err_q || ((state == ST_DIGIT) && cur_bad);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (trigger) state_nxt = ST_DIGIT;
      ST_DIGIT: if (xfer && (idx == LAST_IDX)) state_nxt = (ADD_CRLF != 0) ? ST_CR : ST_IDLE;
      ST_CR:    if (xfer) state_nxt = ST_LF;
      ST_LF:    if (xfer) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      snapshot  <= '0;
      last_sent <= '1;
      pending   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && trigger) begin
        snapshot <= ss_in;
        err_q    <= 1'b0;
        idx      <= '0;
      end else if ((state == ST_DIGIT) && xfer && (idx != LAST_IDX)) begin
        idx <= idx + 1'b1;
      end

      if ((state == ST_DIGIT) && cur_bad) err_q <= 1'b1;

      if ((state != ST_IDLE) && (state_nxt == ST_IDLE)) last_sent <= snapshot;

      // In IDLE a pending request is always consumed as a trigger.
      if (state == ST_IDLE) pending <= 1'b0;
      else if (start)       pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_segment_ascii_streamer.sv
module tb_segment_ascii_streamer;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_X = 7'b0000001;

  logic        clk;
  logic        rst_n, rst_n_b;
  logic [13:0] ss_in, ss_in_b;
  logic        start, start_b;
  logic        busy, busy_b, frame_err, frame_err_b;

  segment_ascii_streamer_if if_a ();
  segment_ascii_streamer_if if_b ();

  segment_ascii_streamer #(.NUM_DIGITS(2), .ADD_CRLF(1), .AUTO_SEND(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .ss_in(ss_in), .start(start),
    .tx(if_a), .busy(busy), .frame_err(frame_err)
  );

  segment_ascii_streamer #(.NUM_DIGITS(2), .ADD_CRLF(1), .AUTO_SEND(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .ss_in(ss_in_b), .start(start_b),
    .tx(if_b), .busy(busy_b), .frame_err(frame_err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;
  int rx_a     = 0;
  int rx_b     = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_a(input logic [7:0] d1, input logic [7:0] d0);
    q_a.push_back(d1); q_a.push_back(d0); q_a.push_back(8'h0D); q_a.push_back(8'h0A);
  endtask

  // Byte monitors: a byte counts when valid&ready is seen mid-cycle.
  logic       hold_a;
  logic [7:0] hold_data_a;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_a = 1'b0;
    end else begin
      if (hold_a) begin
        check_eq("hold_valid", if_a.tx_valid, 1);
        check_eq("hold_data", if_a.tx_data, hold_data_a);
      end
      if (if_a.tx_valid && if_a.tx_ready) begin
        rx_a++;
        if (q_a.size() == 0) check_eq("extra_byte_a", {24'h0, if_a.tx_data}, 32'h100);
        else                 check_eq("byte_a", if_a.tx_data, q_a.pop_front());
      end
      hold_a      = if_a.tx_valid && !if_a.tx_ready;
      hold_data_a = if_a.tx_data;
    end
  end

  always @(negedge clk) begin
    if (rst_n_b && if_b.tx_valid && if_b.tx_ready) begin
      rx_b++;
      if (q_b.size() == 0) check_eq("extra_byte_b", {24'h0, if_b.tx_data}, 32'h100);
      else                 check_eq("byte_b", if_b.tx_data, q_b.pop_front());
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check_eq("latency_valid", if_a.tx_valid, 1);
    check_eq("latency_busy", busy, 1);
  endtask

  // Runs until DUT A is idle with nothing expected; returns busy cycle count.
  task automatic wait_idle(input bit toggle, input int chg_at, input int init, output int cyc);
    bit done;
    done = 1'b0;
    cyc  = init;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
      if (toggle) if_a.tx_ready = ~if_a.tx_ready;
      if (i == chg_at) ss_in = {SEG_9, SEG_9};
      if (busy) cyc++;
      if (q_a.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) check_eq("idle_timeout_a", {busy, 31'(q_a.size())}, 0);
  endtask

  task automatic wait_idle_b();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clk); #1;
      if (q_b.size() == 0 && !busy_b) done = 1'b1;
    end
    if (!done) check_eq("idle_timeout_b", {busy_b, 31'(q_b.size())}, 0);
  endtask

  initial begin
    int cyc;
    int saved;
    rst_n = 1'b0; rst_n_b = 1'b0;
    start = 1'b0; start_b = 1'b0;
    ss_in = '0; ss_in_b = {SEG_2, SEG_3};
    if_a.tx_ready = 1'b1; if_b.tx_ready = 1'b1;

    #3;
    check_eq("rst_valid", if_a.tx_valid, 0);
    check_eq("rst_data", if_a.tx_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", frame_err, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic frame "23" with ready held high
    ss_in = {SEG_2, SEG_3};
    push_a(8'h32, 8'h33);
    pulse_start();
    wait_idle(0, -1, 1, cyc);
    check_eq("busy_cycles_basic", cyc, 4);
    check_eq("err_basic", frame_err, 0);
    check_eq("valid_after_basic", if_a.tx_valid, 0);

    // Back-pressure: ready toggles, ss_in changes mid-frame
    if_a.tx_ready = 1'b0;
    push_a(8'h32, 8'h33);
    pulse_start();
    wait_idle(1, 2, 1, cyc);
    if_a.tx_ready = 1'b1;
    check_eq("busy_after_bp", busy, 0);

    // Unrecognised low digit
    ss_in = {SEG_2, SEG_X};
    push_a(8'h32, 8'h3F);
    pulse_start();
    wait_idle(0, -1, 1, cyc);
    check_eq("err_bad_end", frame_err, 1);
    repeat (3) @(posedge clk);
    #1 check_eq("err_bad_held", frame_err, 1);
    ss_in = {SEG_4, SEG_5};
    push_a(8'h34, 8'h35);
    pulse_start();
    check_eq("err_cleared", frame_err, 0);
    wait_idle(0, -1, 1, cyc);
    check_eq("err_good_end", frame_err, 0);

    // Two starts during a frame: exactly one follow-up frame
    ss_in = {SEG_2, SEG_3};
    push_a(8'h32, 8'h33);
    push_a(8'h32, 8'h33);
    pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle(0, -1, 4, cyc);
    check_eq("busy_cycles_double", cyc, 8);
    saved = rx_a;
    repeat (10) @(posedge clk);
    #1;
    check_eq("no_third_busy", busy, 0);
    check_eq("no_third_bytes", rx_a, saved);

    // Reset after the first byte transfers
    ss_in = {SEG_0, SEG_9};
    push_a(8'h30, 8'h39);
    pulse_start();
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", if_a.tx_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_popped", q_a.size(), 3);
    q_a.delete();
    saved = rx_a;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("post_rst_bytes", rx_a, saved);
    check_eq("post_rst_busy", busy, 0);
    push_a(8'h30, 8'h39);
    pulse_start();
    wait_idle(0, -1, 1, cyc);
    check_eq("busy_cycles_post_rst", cyc, 4);

    // AUTO_SEND instance
    q_b.push_back(8'h32); q_b.push_back(8'h33); q_b.push_back(8'h0D); q_b.push_back(8'h0A);
    @(posedge clk); #1 rst_n_b = 1'b1;
    wait_idle_b();
    check_eq("auto_first_bytes", rx_b, 4);
    repeat (10) @(posedge clk);
    #1;
    check_eq("auto_stable_busy", busy_b, 0);
    check_eq("auto_stable_bytes", rx_b, 4);
    ss_in_b = {SEG_4, SEG_5};
    q_b.push_back(8'h34); q_b.push_back(8'h35); q_b.push_back(8'h0D); q_b.push_back(8'h0A);
    wait_idle_b();
    check_eq("auto_second_bytes", rx_b, 8);
    repeat (10) @(posedge clk);
    #1;
    check_eq("auto_final_bytes", rx_b, 8);
    check_eq("auto_err", frame_err_b, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/segment_ascii_streamer.md
SEGMENT_ASCII_STREAMER -- requirements
Module: segment_ascii_streamer

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 2, meaning the number of 7-segment digits decoded per frame (range 1..8).
REQ-002 SHALL have parameter ADD_CRLF, default 1, meaning a frame ends with 0x0D, 0x0A when 1, and has no terminator when 0.
REQ-003 SHALL have parameter AUTO_SEND, default 0, meaning a frame also starts when ss_in differs from the last-sent snapshot when 1.
REQ-004 SHALL have parameter BAD_CHAR, default 8'h3F, meaning the ASCII byte emitted for an unrecognised segment pattern.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port ss_in, input, 7*NUM_DIGITS bits: segment patterns; the digit in the top 7 bits is most significant and is sent first.
REQ-008 SHALL have port start, input, 1 bit: frame request, sampled every cycle.
REQ-009 SHALL have port tx_data, output, 8 bits: the current ASCII byte.
REQ-010 SHALL have port tx_valid, output, 1 bit: tx_data is valid.
REQ-011 SHALL have port tx_ready, input, 1 bit: the sink accepts the byte.
REQ-012 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-013 SHALL have port frame_err, output, 1 bit: the last or current frame contained at least one BAD_CHAR.

Function
REQ-014 SHALL decode each 7-bit field (bit6=a ... bit0=g, active-high) as follows:
- 1111110->0x30, 0110000->0x31, 1101101->0x32, 1111001->0x33, 0110011->0x34
- 1011011->0x35, 1011111->0x36, 1110000->0x37, 1111111->0x38, 1111011->0x39
- any other pattern -> BAD_CHAR
REQ-015 SHALL implement the FSM IDLE -> DIGIT -> (CR -> LF if ADD_CRLF) -> IDLE.
REQ-016 SHALL define the trigger in IDLE as start=1, or (AUTO_SEND=1 and ss_in != last_sent).
REQ-017 SHALL, on a trigger edge in IDLE: capture ss_in into a snapshot, clear frame_err, set the digit index to 0, and enter DIGIT.
REQ-018 SHALL assert tx_valid and busy in the cycle after the trigger edge (one-cycle latency).
REQ-019 SHALL decode every byte from the snapshot only; ss_in changes mid-frame SHALL NOT affect the frame in progress.
REQ-020 SHALL count a byte as transferred on each rising edge where tx_valid=1 and tx_ready=1.
REQ-021 SHALL hold tx_data and tx_valid stable while tx_valid=1 and tx_ready=0.
REQ-022 SHALL present the next byte in the cycle after a transfer, allowing one byte per cycle when tx_ready is held high.
REQ-023 SHALL, in DIGIT, advance the index on each transfer; the transfer of digit NUM_DIGITS-1 goes to CR (ADD_CRLF=1) or IDLE (ADD_CRLF=0).
REQ-024 SHALL emit 0x0D in CR and 0x0A in LF; the transfer in LF goes to IDLE.
REQ-025 SHALL set frame_err when a BAD_CHAR byte is presented, and hold it until the next frame starts.
REQ-026 SHALL, on entering IDLE, copy the snapshot into last_sent and deassert tx_valid and busy that cycle.
REQ-027 SHALL latch start=1 seen while busy into a one-deep pending flag; further start pulses while pending SHALL be dropped.
REQ-028 SHALL treat a pending flag in IDLE as a trigger; the new frame's tx_valid rises one cycle after IDLE is entered.
REQ-029 SHALL give start=1 no effect on the frame in progress.
REQ-030 SHALL index the digit counter as a $clog2(NUM_DIGITS+1)-bit value that never exceeds NUM_DIGITS-1.

Reset
REQ-031 SHALL, while rst_n=0, immediately force the following, regardless of clk:
- state=IDLE, tx_valid=0, tx_data=0x00, busy=0, frame_err=0
- pending=0, index=0, snapshot=0, last_sent=all-ones
REQ-032 SHALL abort any frame interrupted by reset without completing; the first trigger after reset release starts a fresh frame.
REQ-033 SHALL, with AUTO_SEND=1, send one frame on the first cycle after reset release (ss_in != all-ones last_sent), unless ss_in is all-ones.

Verification
REQ-034 SHALL be verified with NUM_DIGITS=2, ADD_CRLF=1, ss_in={1101101,1111001}, one start pulse, tx_ready=1 -> bytes 0x32,0x33,0x0D,0x0A on 4 consecutive cycles; busy=0 after; frame_err=0.
REQ-035 SHALL be verified with the same frame and tx_ready toggling 0,1 each cycle -> each byte held stable while tx_ready=0; same 4 bytes in order; ss_in changed to "99" mid-frame has no effect.
REQ-036 SHALL be verified with ss_in low digit 0000001 -> bytes 0x32,0x3F,0x0D,0x0A; frame_err=1 until the next start.
REQ-037 SHALL be verified with start pulsed twice during a frame -> exactly one further frame follows immediately after LF; no third frame.
REQ-038 SHALL be verified with AUTO_SEND=1, ss_in held "23" and then changed to "45" -> one frame "23" after reset, idle while stable, then one frame 0x34,0x35,0x0D,0x0A.
REQ-039 SHALL be verified with rst_n pulsed low after the first byte transfers -> tx_valid=0 and busy=0 asynchronously; no further bytes until the next start.
